// File: rtl/rf_iw_fill_ctrl.sv
// Write-side controller for a double-buffered activation/weight RF: packs a
// valid/ready global-buffer stream into DEPTH-entry tiles and ping-pongs the buffers.
module rf_iw_fill_ctrl #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 2,
  parameter int DEPTH         = 4,
  parameter int TILE_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TILE_BITWIDTH-1:0] num_tiles,
  input  logic                     gb_valid,
  input  logic [DATA_BITWIDTH-1:0] gb_data,
  output logic                     gb_ready,
  input  logic                     mac_done,
  output logic                     write_sel,
  output logic                     write_en,
  output logic [ADDR_BITWIDTH-1:0] w_addr,
  output logic [DATA_BITWIDTH-1:0] w_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               dbg_state
);

  // Stream handshake: a beat transfers on a posedge where gb_valid && gb_ready.
  // gb_ready depends only on state, never on gb_valid.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_SWAP = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [TILE_BITWIDTH-1:0]   r_num_tiles;
  logic [TILE_BITWIDTH-1:0]   r_tile_cnt;
  logic [ADDR_BITWIDTH-1:0]   r_fill_cnt;
  logic                       r_write_sel;
  logic                       r_write_en;
  logic [ADDR_BITWIDTH-1:0]   r_w_addr;
  logic [DATA_BITWIDTH-1:0]   r_w_data;
  logic                       r_rd_valid;
  logic                       r_done;

  logic w_handshake;
  logic w_last_beat;
  logic w_swap;
  logic w_job_start;

  always_comb begin
    w_state_next = r_state;
    w_job_start  = (r_state == S_IDLE) && start;
    w_handshake  = (r_state == S_FILL) && gb_valid;
    w_last_beat  = w_handshake && (r_fill_cnt == LAST_ADDR);
    // mac_done in WAIT_SWAP frees the read buffer and is consumed by the swap itself.
    w_swap       = (r_state == S_WAIT_SWAP) && (!r_rd_valid || mac_done);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (num_tiles != '0) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (w_last_beat) begin
          w_state_next = S_WAIT_SWAP;
        end
      end
      S_WAIT_SWAP: begin
        if (w_swap) begin
          w_state_next = (r_tile_cnt == r_num_tiles) ? S_DRAIN : S_FILL;
        end
      end
      S_DRAIN: begin
        if (mac_done) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_num_tiles <= '0;
      r_tile_cnt  <= '0;
      r_fill_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == S_DONE);
      if (w_job_start && (num_tiles != '0)) begin
        r_num_tiles <= num_tiles;
        r_tile_cnt  <= '0;
        r_fill_cnt  <= '0;
      end else if (w_handshake) begin
        r_fill_cnt <= w_last_beat ? '0 : r_fill_cnt + ADDR_BITWIDTH'(1);
        if (w_last_beat) begin
          r_tile_cnt <= r_tile_cnt + TILE_BITWIDTH'(1);
        end
      end
    end
  end

  // Buffer ownership; the final write of a tile commits on the swap edge under
  // the old select, so writes never land in the buffer being read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write_sel <= 1'b1;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_swap) begin
        r_write_sel <= ~r_write_sel;
        r_rd_valid  <= 1'b1;
      end else if (mac_done && (r_state != S_WAIT_SWAP)) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write_en <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
    end else begin
      r_write_en <= w_handshake;
      if (w_handshake) begin
        r_w_addr <= r_fill_cnt;
        r_w_data <= gb_data;
      end
    end
  end

  assign gb_ready  = (r_state == S_FILL);
  assign busy      = (r_state != S_IDLE);
  assign write_sel = r_write_sel;
  assign write_en  = r_write_en;
  assign w_addr    = r_w_addr;
  assign w_data    = r_w_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rf_iw_fill_ctrl.sv
// Directed bench for rf_iw_fill_ctrl: per-cycle vector table for a single-tile and
// a zero-tile job, then hand sequences for backpressure, gaps, early mac_done and reset.
module tb_rf_iw_fill_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_tiles = 8'd0;
  logic       gb_valid = 1'b0;
  logic [7:0] gb_data = 8'd0;
  logic       gb_ready;
  logic       mac_done = 1'b0;
  logic       write_sel;
  logic       write_en;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_done   = 0;

  // expected writes: {write_sel, w_addr, w_data}
  logic [10:0] exp_q[$];

  typedef struct {
    logic       start;
    logic [7:0] nt;
    logic       gv;
    logic [7:0] gd;
    logic       md;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       sel;
    logic       rv;
    logic       gr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  rf_iw_fill_ctrl #(
    .DATA_BITWIDTH(8),
    .ADDR_BITWIDTH(2),
    .DEPTH(4),
    .TILE_BITWIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_tiles(num_tiles),
    .gb_valid(gb_valid),
    .gb_data(gb_data),
    .gb_ready(gb_ready),
    .mac_done(mac_done),
    .write_sel(write_sel),
    .write_en(write_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    exp_q.push_back({sel, addr, data});
  endtask

  // One clock; samples outputs 1 time unit after the edge and scores any write.
  task automatic tick();
    logic [10:0] e;
    @(posedge clk);
    #1;
    if (done) n_done++;
    if (write_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_write actual=%0h expected=none",
                 {write_sel, w_addr, w_data});
      end else begin
        e = exp_q.pop_front();
        check("sb_write", 32'({write_sel, w_addr, w_data}), 32'(e));
      end
    end
  endtask

  task automatic send_beat(input logic [7:0] d);
    int guard;
    guard = 0;
    gb_valid = 1'b1;
    gb_data  = d;
    while (!gb_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!gb_ready) begin
      check("beat_timeout", 32'(guard), 32'(0));
    end
    tick();
    gb_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_mac_done();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int d0;
    int ready_seen;

    // start,nt,gv,gd,md | we,addr,data,sel,rv,gr,busy,done
    vecs[0]  = '{1'b1, 8'd1, 1'b0, 8'd0,  1'b0, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 8'd10, 1'b0, 1'b1, 2'd0, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, 8'd11, 1'b0, 1'b1, 2'd1, 8'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'd0, 1'b1, 8'd12, 1'b0, 1'b1, 2'd2, 8'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 8'd13, 1'b0, 1'b1, 2'd3, 8'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, 8'd14, 1'b0, 1'b0, 2'd3, 8'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'd0, 1'b0, 8'd0,  1'b0, 1'b0, 2'd3, 8'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'd0, 1'b0, 8'd0,  1'b1, 1'b0, 2'd3, 8'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'd0, 1'b0, 8'd0,  1'b0, 1'b0, 2'd3, 8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'd0, 1'b0, 8'd0,  1'b0, 1'b0, 2'd3, 8'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'd0, 1'b0, 8'd0,  1'b0, 1'b0, 2'd3, 8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_sel", 32'(write_sel), 32'(1));
    check("rst_write_en", 32'(write_en), 32'(0));
    check("rst_w_addr", 32'(w_addr), 32'(0));
    check("rst_w_data", 32'(w_data), 32'(0));
    check("rst_gb_ready", 32'(gb_ready), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    // single-tile job then zero-tile job, cycle by cycle
    for (int i = 0; i < 4; i++) push_exp(1'b1, 2'(i), 8'(10 + i));
    for (int i = 0; i < 11; i++) begin
      start     = vecs[i].start;
      num_tiles = vecs[i].nt;
      gb_valid  = vecs[i].gv;
      gb_data   = vecs[i].gd;
      mac_done  = vecs[i].md;
      tick();
      check($sformatf("v%0d_write_en", i), 32'(write_en), 32'(vecs[i].we));
      check($sformatf("v%0d_w_addr", i), 32'(w_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_w_data", i), 32'(w_data), 32'(vecs[i].data));
      check($sformatf("v%0d_write_sel", i), 32'(write_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d_gb_ready", i), 32'(gb_ready), 32'(vecs[i].gr));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
    end
    start = 1'b0;
    gb_valid = 1'b0;
    mac_done = 1'b0;
    check("v_sb_drained", 32'(exp_q.size()), 32'(0));

    // three tiles, MAC releases tile 1 late
    do_reset();
    w0 = n_writes;
    for (int i = 0; i < 12; i++) push_exp(((i / 4) % 2) == 0, 2'(i % 4), 8'(20 + i));
    start = 1'b1;
    num_tiles = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'(20 + i));
    gb_valid = 1'b1;
    gb_data = 8'hEE;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gb_ready) ready_seen++;
    end
    check("s2_backpressure", 32'(ready_seen), 32'(0));
    check("s2_sel_tile2", 32'(write_sel), 32'(0));
    check("s2_writes_before_release", 32'(n_writes - w0), 32'(8));
    gb_valid = 1'b0;
    pulse_mac_done();
    check("s2_sel_tile3", 32'(write_sel), 32'(1));
    check("s2_rv_kept", 32'(rd_valid), 32'(1));
    for (int i = 8; i < 12; i++) send_beat(8'(20 + i));
    tick();
    check("s2_wait_mac", 32'(write_sel), 32'(1));
    pulse_mac_done();
    check("s2_sel_final", 32'(write_sel), 32'(0));
    check("s2_drain_ready", 32'(gb_ready), 32'(0));
    pulse_mac_done();
    check("s2_done", 32'(done), 32'(1));
    tick();
    check("s2_idle", 32'(busy), 32'(0));
    check("s2_write_count", 32'(n_writes - w0), 32'(12));
    check("s2_sb_drained", 32'(exp_q.size()), 32'(0));

    // gb_valid gaps 1,0,0,1,...
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(1'b1, 2'(i), 8'(40 + i));
    start = 1'b1;
    num_tiles = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gb_valid = (i % 3) == 0;
      gb_data  = 8'(40 + i / 3);
      tick();
      check($sformatf("s3_we_%0d", i), 32'(write_en), 32'((i % 3) == 0));
      if (i < 9) check($sformatf("s3_ready_%0d", i), 32'(gb_ready), 32'(1));
    end
    gb_valid = 1'b0;
    tick();
    check("s3_swap_sel", 32'(write_sel), 32'(0));
    check("s3_swap_rv", 32'(rd_valid), 32'(1));
    pulse_mac_done();
    check("s3_done", 32'(done), 32'(1));
    tick();
    check("s3_sb_drained", 32'(exp_q.size()), 32'(0));

    // reset after two beats of a tile written into mem2 (write_sel=0)
    d0 = n_done;
    push_exp(1'b0, 2'd0, 8'd60);
    push_exp(1'b0, 2'd1, 8'd61);
    start = 1'b1;
    num_tiles = 8'd1;
    tick();
    start = 1'b0;
    send_beat(8'd60);
    send_beat(8'd61);
    gb_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("r_write_en", 32'(write_en), 32'(0));
    check("r_w_addr", 32'(w_addr), 32'(0));
    check("r_w_data", 32'(w_data), 32'(0));
    check("r_write_sel", 32'(write_sel), 32'(1));
    check("r_rd_valid", 32'(rd_valid), 32'(0));
    check("r_gb_ready", 32'(gb_ready), 32'(0));
    check("r_busy", 32'(busy), 32'(0));
    check("r_done", 32'(done), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    gb_valid = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(1'b1, 2'(i), 8'(70 + i));
    start = 1'b1;
    num_tiles = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'(70 + i));
    tick();
    check("r_swap_sel", 32'(write_sel), 32'(0));
    pulse_mac_done();
    tick();
    check("r_one_done", 32'(n_done - d0), 32'(1));
    check("r_sb_drained", 32'(exp_q.size()), 32'(0));

    // mac_done during FILL of tile 2, with a start pulse while busy
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 8; i++) push_exp(i < 4, 2'(i % 4), 8'(50 + i));
    start = 1'b1;
    num_tiles = 8'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(8'(50 + i));
    check("s4_rv_before", 32'(rd_valid), 32'(1));
    mac_done = 1'b1;
    start = 1'b1;
    num_tiles = 8'd9;
    tick();
    mac_done = 1'b0;
    start = 1'b0;
    check("s4_rv_clear", 32'(rd_valid), 32'(0));
    check("s4_still_fill", 32'(gb_ready), 32'(1));
    send_beat(8'd56);
    send_beat(8'd57);
    check("s4_sel_pre_swap", 32'(write_sel), 32'(0));
    check("s4_wait_ready", 32'(gb_ready), 32'(0));
    tick();
    check("s4_swap_immediate", 32'(write_sel), 32'(1));
    check("s4_swap_rv", 32'(rd_valid), 32'(1));
    check("s4_drain_not_fill", 32'(gb_ready), 32'(0));
    pulse_mac_done();
    check("s4_done", 32'(done), 32'(1));
    tick();
    check("s4_idle", 32'(busy), 32'(0));
    check("s4_one_done", 32'(n_done - d0), 32'(1));
    check("s4_sb_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
